// File: rtl/v_table_init.sv
// Table initialiser and shared write-port arbiter for replicated state SRAM banks.
// Sweeps every entry with a fill pattern after reset or on request, otherwise forwards functional writes.
module v_table_init #(
  parameter int unsigned  N        = 64,
  parameter int unsigned  W        = 32,
  parameter int unsigned  BANKS_N  = 2,
  parameter int unsigned  ADDR_W   = $clog2(N),
  parameter logic [W-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_reinit,
  input  logic               i_reinit_mode,
  input  logic               i_fn_wen,
  input  logic [ADDR_W-1:0]  i_fn_waddr,
  input  logic [W-1:0]       i_fn_wdata,
  output logic [BANKS_N-1:0] o_wen_r,
  output logic [ADDR_W-1:0]  o_waddr_r,
  output logic [W-1:0]       o_wdata_r,
  output logic               o_busy_r,
  output logic               o_done_r,
  output logic               o_drop_r
);

  typedef enum logic {S_INIT, S_IDLE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  state_t             state_q;
  logic [ADDR_W-1:0]  cnt_q;
  logic               mode_q;
  logic [BANKS_N-1:0] wen_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [W-1:0]       wdata_q;
  logic               busy_q;
  logic               done_q;
  logic               drop_q;

  // Address fill pattern: the sweep counter zero-extended or truncated to W bits.
  logic [W-1:0] addr_pat;
  for (genvar gi = 0; gi < W; gi++) begin : g_pat
    if (gi < ADDR_W) begin : g_bit
      assign addr_pat[gi] = cnt_q[gi];
    end else begin : g_zero
      assign addr_pat[gi] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      wen_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          wen_q   <= '1;
          waddr_q <= cnt_q;
          wdata_q <= mode_q ? addr_pat : INIT_VAL;
          busy_q  <= 1'b1;
          if (i_fn_wen) begin
            drop_q <= 1'b1;
          end
          if (i_reinit) begin
            cnt_q  <= '0;
            mode_q <= i_reinit_mode;
          end else if (cnt_q == LAST_ADDR) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + ONE_ADDR;
          end
        end
        S_IDLE: begin
          wen_q <= {BANKS_N{i_fn_wen}};
          if (i_fn_wen) begin
            waddr_q <= i_fn_waddr;
            wdata_q <= i_fn_wdata;
          end
          // busy_q is still high only on the first idle cycle after a sweep.
          done_q <= busy_q;
          busy_q <= 1'b0;
          if (i_reinit) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            mode_q  <= i_reinit_mode;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_INIT;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign o_wen_r   = wen_q;
  assign o_waddr_r = waddr_q;
  assign o_wdata_r = wdata_q;
  assign o_busy_r  = busy_q;
  assign o_done_r  = done_q;
  assign o_drop_r  = drop_q;

endmodule

// File: tb/tb_v_table_init.sv
// Bench for v_table_init: an N=8 instance and a non-power-of-two N=5 instance,
// with scoreboard queues of expected bank writes checked by per-instance monitors.
module tb_v_table_init;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic        wen;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [1:0]  exp_wen;
    logic [2:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Instance A: N=8, W=16, two banks
  logic        rst_a, reinit_a, mode_a, fwen_a;
  logic [2:0]  fwaddr_a;
  logic [15:0] fwdata_a;
  logic [1:0]  wen_a;
  logic [2:0]  waddr_a;
  logic [15:0] wdata_a;
  logic        busy_a, done_a, drop_a;

  v_table_init #(.N(8), .W(16), .BANKS_N(2), .INIT_VAL(16'hA5A5)) dut_a (
    .clk(clk), .rst(rst_a), .i_reinit(reinit_a), .i_reinit_mode(mode_a),
    .i_fn_wen(fwen_a), .i_fn_waddr(fwaddr_a), .i_fn_wdata(fwdata_a),
    .o_wen_r(wen_a), .o_waddr_r(waddr_a), .o_wdata_r(wdata_a),
    .o_busy_r(busy_a), .o_done_r(done_a), .o_drop_r(drop_a)
  );

  // Instance B: N=5, W=8, one bank
  logic        rst_b, reinit_b, mode_b, fwen_b;
  logic [2:0]  fwaddr_b;
  logic [7:0]  fwdata_b;
  logic [0:0]  wen_b;
  logic [2:0]  waddr_b;
  logic [7:0]  wdata_b;
  logic        busy_b, done_b, drop_b;

  v_table_init #(.N(5), .W(8), .BANKS_N(1), .INIT_VAL(8'h3C)) dut_b (
    .clk(clk), .rst(rst_b), .i_reinit(reinit_b), .i_reinit_mode(mode_b),
    .i_fn_wen(fwen_b), .i_fn_waddr(fwaddr_b), .i_fn_wdata(fwdata_b),
    .o_wen_r(wen_b), .o_waddr_r(waddr_b), .o_wdata_r(wdata_b),
    .o_busy_r(busy_b), .o_done_r(done_b), .o_drop_r(drop_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int a, input int d);
    exp_t e;
    e.addr = 3'(a);
    e.data = 16'(d);
    return e;
  endfunction

  // Write monitors: every bank write must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (wen_a != 2'b00) begin
      exp_t e;
      n_checks++;
      $display("write A wen=%b addr=%0d data=%h", wen_a, waddr_a, wdata_a);
      if (qa.size() == 0) begin
        n_errors++;
        $display("FAIL mon_a: unexpected write addr=%0d data=%h", waddr_a, wdata_a);
      end else begin
        e = qa.pop_front();
        if (wen_a !== 2'b11 || waddr_a !== e.addr || wdata_a !== e.data) begin
          n_errors++;
          $display("FAIL mon_a: got wen=%b addr=%0d data=%h expected wen=11 addr=%0d data=%h",
                   wen_a, waddr_a, wdata_a, e.addr, e.data);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (wen_b != 1'b0) begin
      exp_t e;
      n_checks++;
      $display("write B wen=%b addr=%0d data=%h", wen_b, waddr_b, wdata_b);
      if (qb.size() == 0) begin
        n_errors++;
        $display("FAIL mon_b: unexpected write addr=%0d data=%h", waddr_b, wdata_b);
      end else begin
        e = qb.pop_front();
        if (waddr_b !== e.addr || wdata_b !== e.data[7:0]) begin
          n_errors++;
          $display("FAIL mon_b: got addr=%0d data=%h expected addr=%0d data=%h",
                   waddr_b, wdata_b, e.addr, e.data[7:0]);
        end
      end
    end
  end

  // n sweep writes with busy high and no done, then one done pulse, then idle.
  task automatic sweep_a(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      chk({tag, "_busy"}, busy_a, 1);
      chk({tag, "_done_early"}, done_a, 0);
    end
    tick();
    chk({tag, "_busy_end"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 1);
    tick();
    chk({tag, "_done_pulse"}, done_a, 0);
    chk({tag, "_queue_empty"}, qa.size(), 0);
  endtask

  task automatic sweep_b(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      chk({tag, "_busy"}, busy_b, 1);
      chk({tag, "_done_early"}, done_b, 0);
    end
    tick();
    chk({tag, "_busy_end"}, busy_b, 0);
    chk({tag, "_done"}, done_b, 1);
    tick();
    chk({tag, "_done_pulse"}, done_b, 0);
    chk({tag, "_queue_empty"}, qb.size(), 0);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b1, 3'd3, 16'h1234, 2'b11, 3'd3, 16'h1234};
    vecs[1] = '{1'b0, 3'd5, 16'hFFFF, 2'b00, 3'd3, 16'h1234};
    vecs[2] = '{1'b1, 3'd7, 16'h0001, 2'b11, 3'd7, 16'h0001};
    vecs[3] = '{1'b1, 3'd0, 16'h8000, 2'b11, 3'd0, 16'h8000};
    vecs[4] = '{1'b0, 3'd2, 16'h0000, 2'b00, 3'd0, 16'h8000};
    vecs[5] = '{1'b1, 3'd6, 16'hCAFE, 2'b11, 3'd6, 16'hCAFE};

    rst_a = 1; reinit_a = 0; mode_a = 0; fwen_a = 0; fwaddr_a = 0; fwdata_a = 0;
    rst_b = 1; reinit_b = 0; mode_b = 0; fwen_b = 0; fwaddr_b = 0; fwdata_b = 0;
    repeat (3) tick();

    chk("rst_wen_a", wen_a, 0);
    chk("rst_waddr_a", waddr_a, 0);
    chk("rst_wdata_a", wdata_a, 0);
    chk("rst_busy_a", busy_a, 1);
    chk("rst_done_a", done_a, 0);
    chk("rst_drop_a", drop_a, 0);

    // Reset sweep with a functional write that must be dropped
    for (int k = 0; k < 8; k++) qa.push_back(mk(k, 16'hA5A5));
    rst_a = 0;
    tick(); chk("sweep0_busy", busy_a, 1);
    tick(); chk("sweep1_busy", busy_a, 1);
    fwen_a = 1; fwaddr_a = 3'd2; fwdata_a = 16'hDEAD;
    tick(); chk("sweep2_busy", busy_a, 1);
    fwen_a = 0;
    sweep_a(5, "reset_sweep");
    chk("drop_set", drop_a, 1);

    // Functional forwarding vectors
    for (int i = 0; i < 6; i++) begin
      fwen_a = vecs[i].wen; fwaddr_a = vecs[i].addr; fwdata_a = vecs[i].data;
      if (vecs[i].wen) qa.push_back(mk(vecs[i].addr, vecs[i].data));
      tick();
      chk($sformatf("fwd%0d_wen", i), wen_a, vecs[i].exp_wen);
      chk($sformatf("fwd%0d_addr", i), waddr_a, vecs[i].exp_addr);
      chk($sformatf("fwd%0d_data", i), wdata_a, vecs[i].exp_data);
      chk($sformatf("fwd%0d_busy", i), busy_a, 0);
      chk($sformatf("fwd%0d_drop_sticky", i), drop_a, 1);
    end
    fwen_a = 0;
    tick();
    chk("fwd_idle_wen", wen_a, 0);

    // Re-init mode 1 with a same-cycle functional write
    qa.push_back(mk(6, 16'hBEEF));
    for (int k = 0; k < 8; k++) qa.push_back(mk(k, k));
    reinit_a = 1; mode_a = 1; fwen_a = 1; fwaddr_a = 3'd6; fwdata_a = 16'hBEEF;
    tick();
    chk("reinit_fn_wen", wen_a, 2'b11);
    chk("reinit_fn_addr", waddr_a, 6);
    chk("reinit_fn_data", wdata_a, 16'hBEEF);
    chk("reinit_busy", busy_a, 1);
    reinit_a = 0; mode_a = 0; fwen_a = 0;
    sweep_a(8, "reinit_m1");

    // Restart mid-sweep at cnt=4, switching from mode 0 to mode 1
    for (int k = 0; k < 5; k++) qa.push_back(mk(k, 16'hA5A5));
    reinit_a = 1; mode_a = 0;
    tick();
    chk("restart_busy", busy_a, 1);
    reinit_a = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("restart_pre_done", done_a, 0);
    end
    for (int k = 0; k < 8; k++) qa.push_back(mk(k, k));
    reinit_a = 1; mode_a = 1;
    tick();
    chk("restart_at4_done", done_a, 0);
    reinit_a = 0; mode_a = 0;
    sweep_a(8, "restart");

    // Instance B: non-power-of-two depth
    for (int k = 0; k < 5; k++) qb.push_back(mk(k, 16'h003C));
    rst_b = 0;
    tick(); chk("b_sweep0_busy", busy_b, 1);
    fwen_b = 1; fwaddr_b = 3'd1; fwdata_b = 8'h77;
    tick(); chk("b_sweep1_busy", busy_b, 1);
    fwen_b = 0;
    sweep_b(3, "b_reset_sweep");
    chk("b_drop_set", drop_b, 1);

    fwen_b = 1; fwaddr_b = 3'd4; fwdata_b = 8'h5A;
    qb.push_back(mk(4, 16'h005A));
    tick();
    chk("b_fwd_wen", wen_b, 1);
    chk("b_fwd_addr", waddr_b, 4);
    fwen_b = 0;

    // Re-init then reset mid-sweep
    for (int k = 0; k < 3; k++) qb.push_back(mk(k, k));
    reinit_b = 1; mode_b = 1;
    tick();
    chk("b_reinit_busy", busy_b, 1);
    reinit_b = 0; mode_b = 0;
    repeat (3) tick();
    rst_b = 1;
    tick();
    chk("b_rst_wen", wen_b, 0);
    chk("b_rst_addr", waddr_b, 0);
    chk("b_rst_data", wdata_b, 0);
    chk("b_rst_busy", busy_b, 1);
    chk("b_rst_done", done_b, 0);
    chk("b_rst_drop", drop_b, 0);
    chk("b_rst_queue_empty", qb.size(), 0);
    rst_b = 0;
    for (int k = 0; k < 5; k++) qb.push_back(mk(k, 16'h003C));
    sweep_b(5, "b_after_rst");
    repeat (3) tick();
    chk("b_final_queue_empty", qb.size(), 0);
    chk("a_final_queue_empty", qa.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/v_table_init.md
# v_table_init

Parametrised table initialiser and write-port arbiter for the context state tables. It owns the single write port shared by all replicated state SRAM banks, such as the update-pipe and query-pipe copies. After reset, or on a software re-initialisation request, it sweeps every entry with a fill pattern while reporting busy. Otherwise it forwards functional writes from the update pipe, registered, to every bank in lock-step.

## Interface
- N, 64, table depth (entries); N >= 2, need not be a power of two.
- W, 32, entry width in bits; W >= 1.
- BANKS_N, 2, number of replicated SRAM banks driven in lock-step; BANKS_N >= 1.
- ADDR_W, $clog2(N), address width.
- INIT_VAL, '0, W-bit fill value for mode 0.

- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- i_reinit  in  1  re-initialisation request pulse.
- i_reinit_mode  in  1  fill mode for the request: 0 = INIT_VAL; 1 = address pattern (entry a gets a zero-extended/truncated to W).
- i_fn_wen  in  1  functional write enable from the update pipe.
- i_fn_waddr  in  ADDR_W  functional write address.
- i_fn_wdata  in  W  functional write data.
- o_wen_r  out  BANKS_N  per-bank write enable; all bits always equal.
- o_waddr_r  out  ADDR_W  write address, shared by all banks.
- o_wdata_r  out  W  write data, shared by all banks.
- o_busy_r  out  1  sweep in progress; functional writes are not accepted.
- o_done_r  out  1  one-cycle pulse when a sweep completes.
- o_drop_r  out  1  sticky flag: a functional write was dropped while busy.

## Operation
- FSM states:
  - INIT: sweep in progress.
  - IDLE: functional write forwarding.
- Internal state: sweep counter cnt (ADDR_W bits) and latched mode.
- Reset (rst=1 at an edge):
  - state <= INIT, cnt <= 0, mode <= 0.
  - o_wen_r <= 0, o_waddr_r <= 0, o_wdata_r <= 0.
  - o_busy_r <= 1, o_done_r <= 0, o_drop_r <= 0.
- INIT, each cycle:
  - o_wen_r <= all ones, o_waddr_r <= cnt.
  - o_wdata_r <= INIT_VAL in mode 0, cnt in mode 1.
  - cnt <= cnt+1.
- Sweep end: when cnt == N-1, that write is issued and state <= IDLE. The counter never wraps past N-1.
- IDLE, each cycle:
  - o_wen_r <= {BANKS_N{i_fn_wen}}, o_waddr_r <= i_fn_waddr, o_wdata_r <= i_fn_wdata.
  - When i_fn_wen=0, o_waddr_r and o_wdata_r hold their previous values.
- i_reinit in IDLE:
  - The same-cycle functional write is still accepted and forwarded.
  - Next edge: state <= INIT, cnt <= 0, mode <= i_reinit_mode, o_busy_r <= 1.
- i_reinit in INIT: the sweep restarts with cnt <= 0 and mode <= i_reinit_mode. The current-cycle write still goes to the old cnt.
- i_fn_wen while in INIT:
  - The write is dropped and o_drop_r <= 1.
  - o_drop_r clears only on rst.
- o_busy_r <= 1 while in INIT or entering INIT. It goes to 0 on the edge after the write to N-1, together with o_done_r <= 1 for exactly one cycle.
- rst during a sweep aborts it and restarts from entry 0 in mode 0.

## Timing
- Let E0 be the first rising edge with rst=0 after reset.
  - At edge Ek, for k = 0..N-1, o_waddr_r becomes k and o_wen_r becomes all ones.
  - At edge EN, o_busy_r=0 and o_done_r=1; at EN+1, o_done_r=0.
- Reset sweep: N write cycles, with o_busy_r high from reset through EN.
- Functional write latency: 1 cycle from i_fn_wen sampled to o_wen_r asserted. There is no backpressure; upstream must stall on o_busy_r.
- Re-init latency: with i_reinit sampled at edge R, o_busy_r=1 after R, the first sweep write for entry 0 appears at edge R+1, and o_done_r appears after edge R+N+1.
- A functional write on the last sweep cycle (the cycle of the edge writing N-1) is dropped. A functional write on the cycle in which o_busy_r first reads 0 is accepted.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset sweep, N=8 W=16 BANKS_N=2 INIT_VAL=16'hA5A5:
  - Release rst and expect o_wen_r=2'b11 with addresses 0..7 and data A5A5 on 8 consecutive cycles.
  - Then expect o_busy_r=0 and a 1-cycle o_done_r pulse.
- Functional forwarding: in IDLE drive i_fn_wen=1, addr 3, data 16'h1234 -> next cycle o_wen_r=2'b11, o_waddr_r=3, o_wdata_r=1234. With i_fn_wen=0 -> o_wen_r=0.
- Drop while busy: pulse i_fn_wen during the reset sweep -> the write does not appear on the outputs and o_drop_r=1 stays set through later IDLE cycles until rst.
- Re-init mode 1 with a simultaneous write: in IDLE assert i_reinit=1, i_reinit_mode=1 and i_fn_wen (addr 6, data 16'hBEEF) in the same cycle. Expect:
  - the 6/BEEF write first;
  - then writes with data equal to the address for addresses 0..7;
  - then o_done_r.
- Restart mid-sweep: pulse i_reinit at cnt=4 -> the sequence reads 0,1,2,3,4,0,1,...,7 and o_done_r fires exactly once, after the final write.
- Non-power-of-two depth, N=5 (ADDR_W=3): addresses 0..4 only, address 5 is never written, and o_busy_r is low after exactly 5 write cycles. Assert rst mid-sweep -> outputs are reset and the sweep restarts at 0.
